// File: rtl/instr_decode_stage.sv
// LEGv8 decode stage: classifies R/I/D/B/CB/IW, extracts fields and extended immediate.
// One-cycle latency, one per cycle; 2-entry (main + skid) output buffer, in_ready registered.
module instr_decode_stage #(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_LEN-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [2:0]            out_fmt,
  output logic [10:0]           out_opcode,
  output logic [4:0]            out_rm,
  output logic [4:0]            out_rn,
  output logic [4:0]            out_rd,
  output logic [5:0]            out_shamt,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [2:0]            fmt;
    logic [10:0]           opcode;
    logic [4:0]            rm;
    logic [4:0]            rn;
    logic [4:0]            rd;
    logic [5:0]            shamt;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
  } dec_t;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_D   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_CB  = 3'd4;
  localparam logic [2:0] FMT_IW  = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  dec_t                 dec, main_q, skid_q, main_n, skid_n;
  logic                 main_vld, skid_vld, main_vld_n, skid_vld_n, in_ready_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic [63:0]          iw_shifted;
  logic                 accept, deliver;

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[31:21];
    dec.rm      = in_instr[20:16];
    dec.rn      = in_instr[9:5];
    dec.rd      = in_instr[4:0];
    iw_shifted  = {48'b0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
    if (in_instr[31:26] inside {6'b000101, 6'b100101}) begin
      dec.fmt = FMT_B;
      dec.imm = {{(DATA_WIDTH-28){in_instr[25]}}, in_instr[25:0], 2'b00};
    end else if (in_instr[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100}) begin
      dec.fmt = FMT_CB;
      dec.imm = {{(DATA_WIDTH-21){in_instr[23]}}, in_instr[23:5], 2'b00};
    end else if (in_instr[31:23] inside {9'b110100101, 9'b111100101}) begin
      // hw=2/3 would shift the halfword past a 32-bit datapath
      if (DATA_WIDTH == 32 && in_instr[22]) begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end else begin
        dec.fmt = FMT_IW;
        dec.imm = iw_shifted[DATA_WIDTH-1:0];
      end
    end else if (in_instr[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                         10'b1111000100, 10'b1001001000, 10'b1011001000,
                                         10'b1101001000}) begin
      dec.fmt = FMT_I;
      dec.imm = {{(DATA_WIDTH-12){1'b0}}, in_instr[21:10]};
    end else if (in_instr[31:21] inside {11'h7C2, 11'h7C0}) begin
      dec.fmt = FMT_D;
      dec.imm = {{(DATA_WIDTH-9){in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550,
                                         11'h650, 11'h69B, 11'h69A, 11'h6B0}) begin
      dec.fmt   = FMT_R;
      dec.shamt = in_instr[15:10];
    end else begin
      dec.fmt     = FMT_ILL;
      dec.illegal = 1'b1;
    end
  end

  assign accept  = in_valid && in_ready_q;
  assign deliver = main_vld && out_ready;

  always_comb begin
    main_n     = main_q;
    skid_n     = skid_q;
    main_vld_n = main_vld;
    skid_vld_n = skid_vld;
    cnt_n      = cnt_q;
    // the entry leaving in a flush cycle still counts
    if (deliver && main_q.illegal && cnt_q != '1)
      cnt_n = cnt_q + CNT_WIDTH'(1);
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (deliver) begin
      if (skid_vld) begin
        main_n     = skid_q;
        skid_vld_n = 1'b0;
      end else if (accept) begin
        main_n = dec;
      end else begin
        main_vld_n = 1'b0;
      end
    end else if (accept) begin
      if (main_vld) begin
        skid_n     = dec;
        skid_vld_n = 1'b1;
      end else begin
        main_n     = dec;
        main_vld_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_vld   <= main_vld_n;
      skid_vld   <= skid_vld_n;
      in_ready_q <= !skid_vld_n;
      cnt_q      <= cnt_n;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_vld;
  assign out_pc        = main_q.pc;
  assign out_fmt       = main_q.fmt;
  assign out_opcode    = main_q.opcode;
  assign out_rm        = main_q.rm;
  assign out_rn        = main_q.rn;
  assign out_rd        = main_q.rd;
  assign out_shamt     = main_q.shamt;
  assign out_imm       = main_q.imm;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Two decode stages (64-bit/4-bit counter, 32-bit/16-bit counter) share one stimulus stream;
// a monitor pops expected entries produced by a reference decoder and tracks occupancy.
module tb_instr_decode_stage;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [63:0] out_pc_a, out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [10:0] out_opcode_a;
  logic [4:0]  out_rm_a, out_rn_a, out_rd_a;
  logic [5:0]  out_shamt_a;
  logic [3:0]  illegal_count_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_pc_b;
  logic [31:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [10:0] out_opcode_b;
  logic [4:0]  out_rm_b, out_rn_b, out_rd_b;
  logic [5:0]  out_shamt_b;
  logic [15:0] illegal_count_b;

  instr_decode_stage #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_pc(out_pc_a), .out_fmt(out_fmt_a), .out_opcode(out_opcode_a),
    .out_rm(out_rm_a), .out_rn(out_rn_a), .out_rd(out_rd_a), .out_shamt(out_shamt_a),
    .out_imm(out_imm_a), .out_illegal(out_illegal_a), .illegal_count(illegal_count_a));

  instr_decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_pc(out_pc_b), .out_fmt(out_fmt_b), .out_opcode(out_opcode_b),
    .out_rm(out_rm_b), .out_rn(out_rn_b), .out_rd(out_rd_b), .out_shamt(out_shamt_b),
    .out_imm(out_imm_b), .out_illegal(out_illegal_b), .illegal_count(illegal_count_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [10:0] opc;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [5:0]  shamt;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  int          checks = 0, errors = 0;
  exp_t        qa[$], qb[$];
  int          occ = 0, cnta = 0, cntb = 0;
  bit          just_rel = 1'b0;
  logic [63:0] pc_ctr = 64'h1000;

  // Prefixes (value, length) used to steer random words toward each instruction class
  logic [10:0] pv [24] = '{11'b000101, 11'b100101, 11'hB4, 11'hB5, 11'h54,
                           11'b110100101, 11'b111100101,
                           11'b1001000100, 11'b1011000100, 11'b1101000100, 11'b1111000100,
                           11'b1001001000, 11'b1011001000, 11'b1101001000,
                           11'h7C2, 11'h7C0, 11'h458, 11'h658, 11'h450, 11'h550,
                           11'h650, 11'h69B, 11'h69A, 11'h6B0};
  int          pl [24] = '{6, 6, 8, 8, 8, 9, 9, 10, 10, 10, 10, 10, 10, 10,
                           11, 11, 11, 11, 11, 11, 11, 11, 11, 11};

  function automatic exp_t model(logic [31:0] ins, logic [63:0] pc, int dw);
    exp_t   e;
    longint v;
    int     hw;
    e.pc = pc; e.opc = ins[31:21]; e.rm = ins[20:16]; e.rn = ins[9:5]; e.rd = ins[4:0];
    e.shamt = '0; e.ill = 1'b0; e.fmt = 3'd7; v = 0;
    hw = int'(ins[22:21]);
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      e.fmt = 3'd3; v = longint'($signed(ins[25:0])) * 4;
    end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54) begin
      e.fmt = 3'd4; v = longint'($signed(ins[23:5])) * 4;
    end else if (ins[31:23] == 9'b110100101 || ins[31:23] == 9'b111100101) begin
      if (dw == 32 && hw >= 2) e.ill = 1'b1;
      else begin e.fmt = 3'd5; v = longint'(ins[20:5]) << (16 * hw); end
    end else if (ins[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                                    10'b1001001000, 10'b1011001000, 10'b1101001000}) begin
      e.fmt = 3'd1; v = longint'(ins[21:10]);
    end else if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) begin
      e.fmt = 3'd2; v = longint'($signed(ins[20:12]));
    end else if (ins[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h650,
                                    11'h69B, 11'h69A, 11'h6B0}) begin
      e.fmt = 3'd0; e.shamt = ins[15:10];
    end else begin
      e.ill = 1'b1;
    end
    e.imm = (dw == 32) ? {32'h0, v[31:0]} : v;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    int          k;
    logic [31:0] p, r, m;
    k = $urandom_range(0, 24);
    r = $urandom;
    if (k == 24) return r;
    p = 32'(pv[k]);
    m = (32'd1 << (32 - pl[k])) - 32'd1;
    return (p << (32 - pl[k])) | (r & m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t act, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s pc %h/%h fmt %0d/%0d opc %h/%h rm %0d/%0d rn %0d/%0d rd %0d/%0d sh %0d/%0d imm %h/%h ill %0d/%0d (actual/required)",
               tag, act.pc, e.pc, act.fmt, e.fmt, act.opc, e.opc, act.rm, e.rm, act.rn, e.rn,
               act.rd, e.rd, act.shamt, e.shamt, act.imm, e.imm, act.ill, e.ill);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, output bit acc);
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc_ctr; out_ready = ordy; flush = fl;
    acc = v && in_ready_a && !fl && !reset;
    if (acc) begin
      qa.push_back(model(ins, pc_ctr, 64));
      qb.push_back(model(ins, pc_ctr, 32));
      pc_ctr += 64'd4;
    end
  endtask

  task automatic send(input logic [31:0] ins, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin drive(1'b1, ins, ordy, 1'b0, acc); n++; end while (!acc && n < 20);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout instr=%h in_ready stayed 0 for %0d cycles, required 1", ins, n);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    repeat (n) drive(1'b0, 32'h0, ordy, 1'b0, acc);
  endtask

  // Monitor: samples between edges, compares deliveries and handshake state
  initial begin
    exp_t ea, eb, aa, ab;
    bit   rdy_m, dl, ac;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        chk("rst_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
        chk("rst_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
        chk("rst_count", 64'({illegal_count_a, illegal_count_b}), 64'd0);
        chk("rst_data", 64'(|{out_pc_a, out_fmt_a, out_opcode_a, out_rm_a, out_rn_a, out_rd_a,
                                out_shamt_a, out_imm_a, out_illegal_a, out_imm_b, out_fmt_b}), 64'd0);
        qa.delete(); qb.delete();
        occ = 0; cnta = 0; cntb = 0; just_rel = 1'b1;
      end else begin
        rdy_m = !just_rel && occ < 2;
        chk("in_ready_a", 64'(in_ready_a), 64'(rdy_m));
        chk("in_ready_b", 64'(in_ready_b), 64'(rdy_m));
        chk("out_valid_a", 64'(out_valid_a), 64'(occ > 0));
        chk("out_valid_b", 64'(out_valid_b), 64'(occ > 0));
        chk("count_a", 64'(illegal_count_a), 64'(cnta));
        chk("count_b", 64'(illegal_count_b), 64'(cntb));
        dl = (occ > 0) && out_ready;
        ac = in_valid && rdy_m && !flush;
        if (dl && qa.size() > 0 && qb.size() > 0) begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          if (ea.ill) cnta = (cnta < 15) ? cnta + 1 : 15;
          if (eb.ill) cntb = (cntb < 65535) ? cntb + 1 : 65535;
          if (!flush) begin
            aa = {out_pc_a, out_fmt_a, out_opcode_a, out_rm_a, out_rn_a, out_rd_a,
                  out_shamt_a, out_imm_a, out_illegal_a};
            ab = {out_pc_b, out_fmt_b, out_opcode_b, out_rm_b, out_rn_b, out_rd_b,
                  out_shamt_b, 32'h0, out_imm_b, out_illegal_b};
            cmp("entry_dw64", aa, ea);
            cmp("entry_dw32", ab, eb);
          end
        end
        if (flush) begin
          qa.delete(); qb.delete(); occ = 0;
        end else begin
          occ = occ + int'(ac) - int'(dl);
        end
        just_rel = 1'b0;
      end
    end
  end

  initial begin
    bit acc;
    repeat (3) @(negedge clk);
    @(negedge clk); reset = 1'b0;

    // back-to-back directed words, no backpressure
    send(32'hF84F0149, 1'b1);
    send(32'h8B0902AA, 1'b1);
    send(32'h17FFFFFF, 1'b1);
    send(32'hF81FF149, 1'b1);
    send(32'hD2F7DDE1, 1'b1);
    send(32'h00000000, 1'b1);
    idle(3, 1'b1);

    // backpressure: third word waits until skid drains
    send(32'h8B0902AA, 1'b0);
    send(32'hF84F0149, 1'b0);
    repeat (3) drive(1'b1, 32'hD2F7DDE1, 1'b0, 1'b0, acc);
    send(32'hD2F7DDE1, 1'b1);
    idle(3, 1'b1);

    // flush with both entries full, then flush while an illegal head is delivered
    send(32'h8B0902AA, 1'b0);
    send(32'h17FFFFFF, 1'b0);
    drive(1'b1, 32'hF84F0149, 1'b0, 1'b1, acc);
    idle(2, 1'b1);
    send(32'h00000000, 1'b0);
    drive(1'b1, 32'hF84F0149, 1'b1, 1'b1, acc);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) < 7, gen(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, acc);
    idle(3, 1'b1);

    // async reset with both entries holding illegal words
    send(32'h00000000, 1'b0);
    send(32'h00000000, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("arst_immediate", 64'({out_valid_a, out_valid_b, illegal_count_a, illegal_count_b, out_imm_a}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2, 1'b1);

    // counter saturation on the 4-bit instance
    for (int i = 0; i < 19; i++) send(32'h00000000, 1'b1);
    idle(3, 1'b1);
    chk("sat_count_a", 64'(illegal_count_a), 64'd15);
    chk("sat_count_b", 64'(illegal_count_b), 64'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised LEGv8 instruction decode stage for the pipelined core. Sits between fetch (IF/ID) and register read/execute.
- Classifies each 32-bit instruction into R/I/D/B/CB/IW format and extracts register fields, opcode and a sign- or zero-extended immediate.
- Output is buffered behind a valid/ready handshake with a 2-entry skid buffer, a synchronous flush and a saturating illegal-instruction counter.

Parameters:
- INSTR_LEN, 32, instruction width; only 32 is supported.
- DATA_WIDTH, 64, immediate and datapath width; legal values are 32 or 64.
- PC_WIDTH, 64, width of the PC carried alongside the instruction.
- CNT_WIDTH, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven only from registered state.
- in_instr  in  INSTR_LEN  raw instruction.
- in_pc  in  PC_WIDTH  PC of in_instr.
- flush  in  1  synchronous kill of all buffered entries.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accept.
- out_pc  out  PC_WIDTH  PC of the decoded entry.
- out_fmt  out  3  format: 0=R, 1=I, 2=D, 3=B, 4=CB, 5=IW, 7=illegal.
- out_opcode  out  11  instr[31:21].
- out_rm  out  5  instr[20:16].
- out_rn  out  5  instr[9:5].
- out_rd  out  5  instr[4:0] (Rd, or Rt for D/CB).
- out_shamt  out  6  instr[15:10] for R format, else 0.
- out_imm  out  DATA_WIDTH  extended immediate.
- out_illegal  out  1  entry is unrecognised or unsupported.
- illegal_count  out  CNT_WIDTH  saturating count of illegal entries delivered.

Behaviour:
- Reset:
  - Both buffer entries are invalid; out_valid=0; all out_* data outputs and illegal_count are 0.
  - in_ready is held 0 while reset is high, and goes to 1 on the first cycle after release.
- Storage: a main output register plus one skid register.
  - in_ready = !skid_valid, registered.
  - Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
  - Latency: an instruction accepted at edge N appears on out_* after edge N; with no backpressure the stage sustains one instruction per cycle.
- Backpressure: if main is valid, out_ready=0 and an accept occurs, the decoded entry goes into skid and in_ready drops the next cycle. When main is delivered, skid moves into main.
- Simultaneous accept and deliver: main is refilled from skid if skid is valid, otherwise from the input. Order is strictly preserved.
- Flush:
  - Clears both entries at the edge and has priority over a concurrent accept; that input is dropped.
  - Output while flush is high is don't-care; downstream must ignore it.
  - The entry being delivered in the flush cycle still counts toward illegal_count if it is illegal.
- Decode (first match wins), opcode prefixes:
  - B: [31:26] = 000101 (B) or 100101 (BL).
  - CB: [31:24] = 10110100 (CBZ), 10110101 (CBNZ) or 01010100 (B.cond).
  - IW: [31:23] = 110100101 (MOVZ) or 111100101 (MOVK).
  - I: [31:22] in {ADDI 1001000100, ADDIS 1011000100, SUBI 1101000100, SUBIS 1111000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000}.
  - D: 11111000010 (LDUR) or 11111000000 (STUR).
  - R: {ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000, LSL 11010011011, LSR 11010011010, BR 11010110000}.
  - Anything else is illegal.
- Immediate rules:
  - D: sign-extend [20:12].
  - I: zero-extend [21:10].
  - B: sign-extend [25:0] <<2.
  - CB: sign-extend [23:5] <<2.
  - IW: zero-extend [20:5] << (16*[22:21]).
  - R and illegal: imm = 0.
- IW with DATA_WIDTH=32 and hw in {2,3} is illegal.
- An illegal entry has out_fmt=7 and out_illegal=1; its register fields are still extracted.
- illegal_count increments on each delivered illegal entry and saturates at all-ones.

Test Plan:
- Back-to-back 0xF84F0149 (LDUR X9,[X10,#240]) then 0x8B0902AA (ADD X10,X21,X9), out_ready=1 -> one result per cycle, 1-cycle latency.
  - LDUR: fmt=2, opcode=0x7C2, rn=10, rd=9, imm=240.
  - ADD: fmt=0, opcode=0x458, rm=9, rn=21, rd=10, imm=0.
- 0x17FFFFFF (B, imm26=-1) -> fmt=3, imm=0xFFFF_FFFF_FFFF_FFFC; 0xF81FF149 (STUR, offset -1) -> imm=all-ones.
- MOVZ X1,#0xBEEF,LSL #48 (0xD2F7DDE1) -> imm=0xBEEF_0000_0000_0000 at DATA_WIDTH=64; same instruction at DATA_WIDTH=32 -> out_illegal=1, illegal_count=1.
- Hold out_ready=0 and offer 3 instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd accept; release out_ready -> all 3 delivered in order, 3rd accepted once skid drains.
- Fill both entries, assert flush together with in_valid -> out_valid=0 next cycle, input dropped, in_ready=1; async reset mid-stream -> outputs and counter 0 immediately, no further deliveries.
- Deliver 2^CNT_WIDTH+3 illegal words (0x00000000) with CNT_WIDTH=4 -> illegal_count saturates at 15.
